// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-programmable LEN-bit pattern, selectable
// overlapping/non-overlapping detection and a saturating match counter.
module seq_detect_param #(
    parameter int unsigned    LEN         = 3,
    parameter int unsigned    CNT_W       = 8,
    parameter logic [LEN-1:0] RST_PATTERN = LEN'(3'b110)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             in,
    input  logic             overlap,
    input  logic             cfg_load,
    input  logic [LEN-1:0]   cfg_pattern,
    input  logic             clr_count,
    output logic             match,
    output logic [CNT_W-1:0] match_count
);

    localparam int unsigned   FW   = $clog2(LEN + 1);
    localparam logic [FW-1:0] FULL = FW'(LEN);

    logic [LEN-1:0]   pattern_q;
    logic [LEN-1:0]   hist_q;
    logic [LEN-1:0]   hist_n;
    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    fill_n;
    logic [FW-1:0]    fill_d;
    logic             match_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             accept;
    logic             hit;

    always_comb begin
        // A pattern load takes the cycle; any bit presented with it is dropped.
        accept = in_valid && !cfg_load;
        hist_n = {hist_q[LEN-2:0], in};
        fill_n = (fill_q == FULL) ? FULL : fill_q + FW'(1);
        hit    = accept && (fill_n == FULL) && (hist_n == pattern_q);

        fill_d = fill_q;
        if (cfg_load) begin
            fill_d = '0;
        end else if (accept) begin
            // Non-overlapping mode forgets the history that formed the match.
            fill_d = (hit && !overlap) ? '0 : fill_n;
        end

        count_d = count_q;
        if (clr_count) begin
            count_d = hit ? CNT_W'(1) : '0;
        end else if (hit && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q <= RST_PATTERN;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            if (cfg_load) begin
                pattern_q <= cfg_pattern;
            end
            if (accept) begin
                hist_q <= hist_n;
            end
            fill_q  <= fill_d;
            match_q <= hit;
            count_q <= count_d;
        end
    end

    assign match       = match_q;
    assign match_count = count_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param (LEN=3, CNT_W=2): each stimulus cycle queues
// its hand-computed match/count, and a negedge monitor pops and compares.
module tb_seq_detect_param;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic       din;
    logic       overlap;
    logic       cfg_load;
    logic [2:0] cfg_pattern;
    logic       clr_count;
    logic       match;
    logic [1:0] match_count;

    typedef struct {
        logic       m;
        logic [1:0] c;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    seq_detect_param #(
        .LEN(3),
        .CNT_W(2),
        .RST_PATTERN(3'b110)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in(din),
        .overlap(overlap),
        .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern),
        .clr_count(clr_count),
        .match(match),
        .match_count(match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks = checks + 1;
            if (match !== e.m) begin
                errors = errors + 1;
                $display("FAIL match step %0d: got %b expected %b", e.id, match, e.m);
            end
            checks = checks + 1;
            if (match_count !== e.c) begin
                errors = errors + 1;
                $display("FAIL match_count step %0d: got %0d expected %0d",
                         e.id, match_count, e.c);
            end
        end
    end

    task automatic step(input logic iv, input logic b, input logic ov, input logic ld,
                        input logic [2:0] pat, input logic clr,
                        input logic em, input logic [1:0] ec);
        exp_t x;
        in_valid    = iv;
        din         = b;
        overlap     = ov;
        cfg_load    = ld;
        cfg_pattern = pat;
        clr_count   = clr;
        @(posedge clk);
        x.m  = em;
        x.c  = ec;
        x.id = step_id;
        exp_q.push_back(x);
        step_id = step_id + 1;
        #1;
        in_valid  = 1'b0;
        din       = 1'b0;
        cfg_load  = 1'b0;
        clr_count = 1'b0;
    endtask

    task automatic bit_in(input logic b, input logic ov, input logic em, input logic [1:0] ec);
        step(1'b1, b, ov, 1'b0, 3'b000, 1'b0, em, ec);
    endtask

    task automatic idle(input logic em, input logic [1:0] ec);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, em, ec);
    endtask

    task automatic clr_load(input logic ld, input logic [2:0] pat);
        step(1'b0, 1'b0, 1'b0, ld, pat, 1'b1, 1'b0, 2'd0);
    endtask

    initial begin
        exp_t x;
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        din         = 1'b0;
        overlap     = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = 3'b000;
        clr_count   = 1'b0;
        // Reset state, checked while reset is still asserted.
        x.m = 1'b0; x.c = 2'd0; x.id = -1;
        exp_q.push_back(x);
        @(negedge clk);
        #3 reset_n = 1'b1;

        // Default pattern 110, consecutive bits 0,1,1,0, non-overlapping.
        bit_in(1'b0, 1'b0, 1'b0, 2'd0);
        bit_in(1'b1, 1'b0, 1'b0, 2'd0);
        bit_in(1'b1, 1'b0, 1'b0, 2'd0);
        bit_in(1'b0, 1'b0, 1'b1, 2'd1);
        idle(1'b0, 2'd1);

        // Same stream with three idle cycles between bits.
        clr_load(1'b0, 3'b000);
        bit_in(1'b0, 1'b0, 1'b0, 2'd0);
        repeat (3) idle(1'b0, 2'd0);
        bit_in(1'b1, 1'b0, 1'b0, 2'd0);
        repeat (3) idle(1'b0, 2'd0);
        bit_in(1'b1, 1'b0, 1'b0, 2'd0);
        repeat (3) idle(1'b0, 2'd0);
        bit_in(1'b0, 1'b0, 1'b1, 2'd1);
        idle(1'b0, 2'd1);

        // Pattern 101, overlapping: hits on bits 3 and 5.
        clr_load(1'b1, 3'b101);
        bit_in(1'b1, 1'b1, 1'b0, 2'd0);
        bit_in(1'b0, 1'b1, 1'b0, 2'd0);
        bit_in(1'b1, 1'b1, 1'b1, 2'd1);
        bit_in(1'b0, 1'b1, 1'b0, 2'd1);
        bit_in(1'b1, 1'b1, 1'b1, 2'd2);
        idle(1'b0, 2'd2);

        // Pattern 101, non-overlapping: hit on bit 3 only.
        clr_load(1'b1, 3'b101);
        bit_in(1'b1, 1'b0, 1'b0, 2'd0);
        bit_in(1'b0, 1'b0, 1'b0, 2'd0);
        bit_in(1'b1, 1'b0, 1'b1, 2'd1);
        bit_in(1'b0, 1'b0, 1'b0, 2'd1);
        bit_in(1'b1, 1'b0, 1'b0, 2'd1);
        idle(1'b0, 2'd1);

        // Async reset mid-cycle after a 1,1 prefix; pattern must revert to 110.
        bit_in(1'b1, 1'b0, 1'b0, 2'd1);
        bit_in(1'b1, 1'b0, 1'b0, 2'd1);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        bit_in(1'b0, 1'b0, 1'b0, 2'd0);
        bit_in(1'b1, 1'b0, 1'b0, 2'd0);
        bit_in(1'b1, 1'b0, 1'b0, 2'd0);
        bit_in(1'b0, 1'b0, 1'b1, 2'd1);

        // Saturation with CNT_W=2: five hits count 1,2,3,3,3.
        clr_load(1'b0, 3'b000);
        bit_in(1'b1, 1'b0, 1'b0, 2'd0);
        bit_in(1'b1, 1'b0, 1'b0, 2'd0);
        bit_in(1'b0, 1'b0, 1'b1, 2'd1);
        bit_in(1'b1, 1'b0, 1'b0, 2'd1);
        bit_in(1'b1, 1'b0, 1'b0, 2'd1);
        bit_in(1'b0, 1'b0, 1'b1, 2'd2);
        bit_in(1'b1, 1'b0, 1'b0, 2'd2);
        bit_in(1'b1, 1'b0, 1'b0, 2'd2);
        bit_in(1'b0, 1'b0, 1'b1, 2'd3);
        bit_in(1'b1, 1'b0, 1'b0, 2'd3);
        bit_in(1'b1, 1'b0, 1'b0, 2'd3);
        bit_in(1'b0, 1'b0, 1'b1, 2'd3);
        bit_in(1'b1, 1'b0, 1'b0, 2'd3);
        bit_in(1'b1, 1'b0, 1'b0, 2'd3);
        bit_in(1'b0, 1'b0, 1'b1, 2'd3);
        // Sixth hit with clr_count on the same edge -> count 1.
        bit_in(1'b1, 1'b0, 1'b0, 2'd3);
        bit_in(1'b1, 1'b0, 1'b0, 2'd3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 2'd1);
        idle(1'b0, 2'd1);

        // cfg_load wins over a completing bit; fill restarts from zero.
        clr_load(1'b1, 3'b110);
        bit_in(1'b1, 1'b0, 1'b0, 2'd0);
        bit_in(1'b1, 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 2'd0);
        bit_in(1'b0, 1'b0, 1'b0, 2'd0);
        bit_in(1'b1, 1'b0, 1'b0, 2'd0);
        bit_in(1'b1, 1'b0, 1'b0, 2'd0);
        bit_in(1'b0, 1'b0, 1'b1, 2'd1);

        // Self-overlapping 111, overlapping mode: strobes on consecutive cycles.
        clr_load(1'b1, 3'b111);
        bit_in(1'b1, 1'b1, 1'b0, 2'd0);
        bit_in(1'b1, 1'b1, 1'b0, 2'd0);
        bit_in(1'b1, 1'b1, 1'b1, 2'd1);
        bit_in(1'b1, 1'b1, 1'b1, 2'd2);
        idle(1'b0, 2'd2);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised successor to the fixed 3-bit "110" serial detector. Matches a runtime-programmable LEN-bit pattern on a qualified serial bit stream.
- Selectable overlapping / non-overlapping detection, plus a saturating match counter.
- Sits between a serial source (UART/bit-slicer) and control logic that needs a one-cycle match strobe and a match tally.

Parameters:
- LEN, 3, pattern length in bits; legal range 2..32.
- CNT_W, 8, width of match_count.
- RST_PATTERN, 3'b110 (LEN bits), pattern loaded at reset.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies `in`; a bit is accepted only on a clk edge with in_valid=1.
- in  input  1  serial data bit.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled on the edge that accepts the completing bit.
- cfg_load  input  1  load cfg_pattern into the pattern register.
- cfg_pattern  input  LEN  new pattern; MSB is the first bit expected on the wire.
- clr_count  input  1  synchronous clear of match_count.
- match  output  1  registered one-cycle strobe, high in the cycle after the completing bit is accepted.
- match_count  output  CNT_W  number of matches since reset or clear; saturates.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - pattern = RST_PATTERN.
  - hist = 0, fill = 0.
  - match = 0, match_count = 0.
- State:
  - pattern[LEN-1:0].
  - hist[LEN-1:0]: shift register; newest bit in bit 0.
  - fill: count of valid history bits, 0..LEN, width clog2(LEN+1).
- Accepted bit (in_valid=1, cfg_load=0):
  - hist_n = {hist[LEN-2:0], in}.
  - fill_n = min(fill+1, LEN).
  - hit = (fill_n==LEN) && (hist_n==pattern).
- Registered updates:
  - hist <= hist_n.
  - match <= hit.
  - If hit and overlap=0: fill <= 0 (history discarded; the next match needs LEN fresh bits).
  - Otherwise: fill <= fill_n.
- Latency: match rises exactly 1 clk after the edge that accepts the last pattern bit and lasts 1 cycle. This is the same Moore timing as the existing detector.
- in_valid=0: hist and fill hold; match <= 0. Gaps of any length between bits do not break a partial match.
- Back-to-back hits (overlap=1, self-overlapping pattern): match may be high on consecutive cycles, one strobe per accepted completing bit.
- cfg_load=1:
  - pattern <= cfg_pattern; fill <= 0; match <= 0.
  - Has priority over in_valid: a bit presented in the same cycle is dropped.
  - match_count is unaffected.
- match_count:
  - Increments on the same edge that sets match.
  - Saturates at 2^CNT_W-1 and never wraps.
  - clr_count alone: count <= 0.
  - clr_count together with hit: count <= 1.
- No FSM encoding of the pattern. The detector is the history/fill datapath above; hard-coded state lists are not permitted.
- Asynchronous reset mid-sequence discards all partial history immediately.
- Outputs come directly from flops; no combinational path from inputs to outputs.

Test Plan:
- Default pattern 110, overlap=0, bits 0,1,1,0 on consecutive cycles -> match=1 only in the cycle after the 4th bit; match_count=1.
- Same stream with in_valid=0 for 3 cycles between every bit -> single match strobe 1 cycle after the final 0 is accepted; count=1.
- cfg_load with cfg_pattern=101, stream 1,0,1,0,1:
  - overlap=1 -> strobes after bits 3 and 5, count=2.
  - overlap=0 -> strobe after bit 3 only, count=1.
- Bits 1,1 accepted, then reset_n pulsed low mid-cycle, then bit 0 -> match stays 0; count=0; pattern back to 110.
- CNT_W=2, five 110 matches -> count 1,2,3,3,3. clr_count asserted on the edge of a 6th hit -> count=1.
- cfg_load=1 with in_valid=1, in=0 after a 1,1 prefix -> bit dropped, no match, fill=0; the next 1,1,0 -> match.
